rs232_receive_fifo: RTL
=======================

# rs232_receive_fifo

Parametrised RS232 receiver with a buffered output and hardware flow control. It supports a configurable character format (5–9 data bits, none/odd/even parity) and flags parity and framing errors per character. Characters are stored in a first-word-fall-through FIFO drained through a valid/ready handshake, and `rs232_rts_n` throttles the remote sender before the FIFO overflows. It sits between the board's asynchronous TXD pin and any streaming consumer in the design.

## Interface
- `CLOCK_FREQ`, 133000000, clock frequency in Hz; need not be a multiple of the baud rate.
- `BAUD_RATE`, 115200, line rate in bit/s.
- `DATA_BITS`, 8, data bits per character, 5..9.
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even.
- `FIFO_DEPTH`, 16, number of FIFO entries; power of two, at least 4.
- `RTS_MARGIN`, 4, free-slot threshold for RTS; must be less than FIFO_DEPTH.

Ports:
- `clock`, input, 1, system clock.
- `reset_n`, input, 1, asynchronous active-low reset; clock is `clock`.
- `rs232_txd`, input, 1, asynchronous serial line; idles high.
- `rs232_rts_n`, output, 1, registered; 0 = remote may send.
- `data`, output, DATA_BITS, FIFO head character, LSB first on the wire.
- `parity_error`, output, 1, parity error flag of the head entry.
- `frame_error`, output, 1, framing error flag of the head entry (stop bit sampled low).
- `valid`, output, 1, FIFO non-empty.
- `ready`, input, 1, consumer accepts the head entry when `valid && ready`.
- `overrun`, output, 1, one-cycle pulse when a completed character is dropped because the FIFO is full.

## Operation
- **Synchronizer:** `rs232_txd` passes through a 2-FF synchronizer, reset to 1. All logic below uses the synchronized line `txd`.
- **Character format:** NBITS = 1 (start) + DATA_BITS + (PARITY != 0) + 1 (stop).
- **Sample points:** cycle T0 is the first cycle with `txd == 0` while in IDLE. Sample k (k = 0..NBITS-1) is taken at T0 + floor(CLOCK_FREQ*(2k+1)/(2*BAUD_RATE)).
  - The error must not accumulate. Use an exact per-sample constant compare or a fractional accumulator.
  - A fixed integer divider is not acceptable.
- **States:** IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE -> START on `txd == 0`.
  - START: at sample 0, `txd == 1` is a false start -> IDLE with nothing written; otherwise -> DATA.
  - DATA: shifts in DATA_BITS samples, LSB first; -> PARITY if PARITY != 0, else -> STOP.
  - PARITY: odd mode requires XOR(data, parity bit) = 1; even mode requires 0. A mismatch sets `parity_error`.
  - STOP: stop sample 1 -> write the entry, go to IDLE. Stop sample 0 -> write the entry with `frame_error = 1`, go to BREAK.
  - BREAK: waits for `txd == 1`, then -> IDLE. A held-low line therefore yields exactly one entry.
- **FIFO:** each entry is {frame_error, parity_error, data}, written in arrival order.
  - Occupancy counter is $clog2(FIFO_DEPTH+1) bits wide; read and write pointers wrap modulo FIFO_DEPTH.
  - A write in the same cycle as a read when full is accepted; the read frees the slot.
  - A write when full with no read drops the character and pulses `overrun`; FIFO contents are unchanged.
  - A read is `valid && ready`. The head entry holds stable while `valid && !ready`.
- **Flow control:** `rs232_rts_n` is registered as (FIFO_DEPTH - count <= RTS_MARGIN). It does not affect reception; characters keep arriving and may overrun.

## Timing
- **Reset values:** `valid` 0, `overrun` 0, `rs232_rts_n` 1, `data` 0, `parity_error` 0, `frame_error` 0. FIFO empty, state IDLE.
- **After reset release:** `rs232_rts_n` falls on the first clock edge.
- **Reset mid-character:** the partial character is discarded, with no write and no pulse.
- **Pin-to-decision latency:** 2 cycles for the synchronizer. T0 is 2 cycles after the pin falls.
- **Write timing:** the write occurs on the edge ending the stop-sample cycle S. `valid` (if the FIFO was empty) and `overrun` are high in cycle S+1.
- **Read timing:** on a read, the next entry (or `valid = 0`) appears the following cycle. The FIFO sustains one read per cycle.
- **RTS timing:** `rs232_rts_n` reflects the occupancy of the previous cycle (1-cycle lag).
- **Default sample points (8N1, 133 MHz, 115200 baud):** sample 0 at T0+577, sample 1 at T0+1731, stop sample at T0+10967.

## Test plan
- **8N1 default:** drive 0xA5 at the exact baud rate -> one entry {0,0,0xA5}; `valid` high at T0+10968; no `overrun`.
- **Parity and 7-bit mode:** set PARITY=2, DATA_BITS=7; send 0x3C with parity bit 1 (wrong), then 0x3C with parity bit 0 -> entries {0,1,0x3C} then {0,0,0x3C}.
- **Glitch and baud tolerance:** a 100-cycle low glitch -> no entry, state back in IDLE. Then 0x55 sent at +2% baud -> 0x55 with no errors.
- **Break:** hold the line low for 20 bit times, then high -> exactly one entry {1,0,0x00}. A following 0x12 is received correctly.
- **Overrun and RTS:** with `ready = 0`, FIFO_DEPTH=16 and RTS_MARGIN=4, send 17 characters 0x00..0x10.
  - `rs232_rts_n` rises the cycle after the 12th write.
  - The 17th character pulses `overrun`.
  - With `ready = 1`, the reads return 0x00..0x0F in order and `rs232_rts_n` returns to 0.
  - Also cover a simultaneous read and write at full: the write is accepted.
- **Reset mid-character:** pulse `reset_n` low during data bit 3 -> all outputs at their reset values and the FIFO empty. The next full character 0xC3 is received correctly.

Source files
------------

// File: rtl/rs232_receive_fifo.sv
// rs232_receive_fifo: RS232 receiver with parity/framing checks, a first-word-fall-through FIFO
// and RTS flow control. Sample points come from an exact fractional accumulator.
module rs232_receive_fifo #(
    parameter int CLOCK_FREQ = 133000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16,
    parameter int RTS_MARGIN = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 rs232_txd,
    output logic                 rs232_rts_n,
    output logic [DATA_BITS-1:0] data,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 valid,
    input  logic                 ready,
    output logic                 overrun
);
    localparam int NBITS = DATA_BITS + (PARITY != 0 ? 3 : 2);
    localparam int CW = $clog2((CLOCK_FREQ / BAUD_RATE + 1) * (NBITS + 1) + 1);
    localparam int FW = $clog2(4 * BAUD_RATE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] T0_Q = CW'(CLOCK_FREQ / (2 * BAUD_RATE));
    localparam logic [FW-1:0] T0_R = FW'(CLOCK_FREQ % (2 * BAUD_RATE));
    localparam logic [CW-1:0] INC_Q = CW'(CLOCK_FREQ / BAUD_RATE);
    localparam logic [FW-1:0] INC_R = FW'(2 * (CLOCK_FREQ % BAUD_RATE));
    localparam logic [FW-1:0] TWO_B = FW'(2 * BAUD_RATE);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [NW-1:0] DEPTH = NW'(FIFO_DEPTH);
    localparam logic [NW-1:0] MARGIN = NW'(RTS_MARGIN);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    state_t               state;
    logic                 sync1, txd;
    logic [CW-1:0]        cnt, target;
    logic [FW-1:0]        frac, fsum;
    logic [BW-1:0]        bcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr, carry, hit, wr, rd, full, wr_ok;
    logic [DATA_BITS+1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wptr, rptr;
    logic [NW-1:0]        count;

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) {txd, sync1} <= 2'b11;
        else {txd, sync1} <= {sync1, rs232_txd};

    // target holds floor(CLOCK_FREQ*(2k+1)/(2*BAUD_RATE)); frac is the exact remainder
    assign fsum  = frac + INC_R;
    assign carry = fsum >= TWO_B;
    assign hit   = state != S_IDLE && state != S_BREAK && cnt == target;
    assign wr    = state == S_STOP && hit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            target <= '0;
            frac   <= '0;
            bcnt   <= '0;
            shreg  <= '0;
            perr   <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            if (hit) begin
                target <= target + INC_Q + CW'(carry);
                frac   <= carry ? fsum - TWO_B : fsum;
            end
            case (state)
                S_IDLE: if (!txd) begin
                    state  <= S_START;
                    cnt    <= CW'(1);
                    target <= T0_Q;
                    frac   <= T0_R;
                    bcnt   <= '0;
                    perr   <= 1'b0;
                end
                S_START: if (hit) state <= txd ? S_IDLE : S_DATA;
                S_DATA: if (hit) begin
                    shreg <= {txd, shreg[DATA_BITS-1:1]};
                    bcnt  <= bcnt + 1'b1;
                    if (bcnt == LAST_BIT) state <= PARITY != 0 ? S_PARITY : S_STOP;
                end
                S_PARITY: if (hit) begin
                    perr  <= ^shreg ^ txd ^ (PARITY == 1);
                    state <= S_STOP;
                end
                S_STOP: if (hit) state <= txd ? S_IDLE : S_BREAK;
                S_BREAK: if (txd) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign valid = count != '0;
    assign full  = count == DEPTH;
    assign rd    = valid && ready;
    assign wr_ok = wr && (!full || rd);
    assign {frame_error, parity_error, data} = valid ? mem[rptr] : '0;

    always_ff @(posedge clock)
        if (wr_ok) mem[wptr] <= {~txd, perr, shreg};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            overrun     <= 1'b0;
            rs232_rts_n <= 1'b1;
        end else begin
            wptr        <= wptr + AW'(wr_ok);
            rptr        <= rptr + AW'(rd);
            count       <= count + NW'(wr_ok) - NW'(rd);
            overrun     <= wr && !wr_ok;
            rs232_rts_n <= DEPTH - count <= MARGIN;
        end
    end
endmodule
